// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage forwarding / hazard unit.
// REG_AW and SEL_W live here because the tracker entry layout and the
// select encoding both depend on them; every file sees the same values.
package fwd_pkg;

    localparam int REG_AW      = 5;   // 32 architectural registers, x0 reads as zero
    localparam int SEL_W       = 2;   // select width of the 4:1 operand mux
    localparam int STALL_CNT_W = 32;  // stall-cycle counter width (optional counter)

    // Operand-mux select encoding
    localparam logic [SEL_W-1:0] FWD_REG   = 2'b00;  // register-file operand
    localparam logic [SEL_W-1:0] FWD_EXMEM = 2'b01;  // EX/MEM ALU result
    localparam logic [SEL_W-1:0] FWD_MEMWB = 2'b10;  // MEM/WB write-back data
    localparam logic [SEL_W-1:0] FWD_RSVD  = 2'b11;  // reserved, never driven

    // One in-flight instruction as seen by the forwarding logic
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } fwd_entry_t;

    localparam fwd_entry_t FWD_BUBBLE = '0;

    // Entry produces a value that the consumer of register rs needs.
    // x0 never matches, so reads of x0 always come from the register file.
    function automatic logic fwd_hit(input fwd_entry_t e, input logic [REG_AW-1:0] rs);
        return e.valid && e.reg_write && (e.rd != '0) && (e.rd == rs);
    endfunction

    // Younger producer (EX/MEM) wins over the older one (MEM/WB).
    function automatic logic [SEL_W-1:0] fwd_select(input fwd_entry_t exmem,
                                                    input fwd_entry_t memwb,
                                                    input logic [REG_AW-1:0] rs);
        if (fwd_hit(exmem, rs))      return FWD_EXMEM;
        else if (fwd_hit(memwb, rs)) return FWD_MEMWB;
        else                         return FWD_REG;
    endfunction

endpackage

// File: rtl/fwd_stage_tracker.sv
// Destination-register tracker for the EX, MEM and WB stages.
// EX and MEM are held in flops. The WB entry only matters at the edge it is
// formed (when the next consumer enters EX), so it is exported as the value
// MEM hands over at that edge; after that the instruction retires and no
// longer influences forwarding, so it needs no storage of its own.
module fwd_stage_tracker
    import fwd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_en,    // ID instruction advances into EX this edge
    input  logic       flush,      // kill ID and EX contents this edge
    input  fwd_entry_t id_entry,
    output fwd_entry_t ex_entry,   // instruction currently in EX
    output fwd_entry_t mem_next,   // entry entering MEM at the coming edge
    output fwd_entry_t wb_next     // entry entering WB at the coming edge
);

    fwd_entry_t ex_q, ex_d;
    fwd_entry_t mem_q, mem_d;

    // Next-state: ID or bubble into EX, EX (or bubble on flush) into MEM
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        ex_d  = FWD_BUBBLE;
        mem_d = ex_q;
        if (load_en && !flush) ex_d = id_entry;
        if (flush)             mem_d = FWD_BUBBLE;
    end

    // Pipeline shift with synchronous reset to an empty pipeline
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values, independent of statement order.
        if (rst) begin
            ex_q  <= FWD_BUBBLE;
            mem_q <= FWD_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
        end
    end

    assign ex_entry = ex_q;
    assign mem_next = mem_d;
    assign wb_next  = mem_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding control and load-use hazard detection.
// Drives the registered 2-bit selects of both ALU operand muxes and a
// one-cycle stall/bubble for load-use hazards.
// Optional feature: define FWD_STALL_CNT_EN to add the stall_count port and a
// free-running (wrapping) count of stall cycles since reset.
module fwd_hazard_unit
    import fwd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_count
`endif
);

    fwd_entry_t id_entry;
    fwd_entry_t ex_entry;
    fwd_entry_t mem_next;
    fwd_entry_t wb_next;
    logic       load_en;
    logic       load_use;

    logic [SEL_W-1:0] fwd_a_q, fwd_a_d;
    logic [SEL_W-1:0] fwd_b_q, fwd_b_d;

    assign id_entry = '{valid:     id_valid,
                        rd:        id_rd,
                        reg_write: id_reg_write,
                        mem_read:  id_mem_read};

    fwd_stage_tracker u_tracker (
        .clk      (clk),
        .rst      (rst),
        .load_en  (load_en),
        .flush    (flush),
        .id_entry (id_entry),
        .ex_entry (ex_entry),
        .mem_next (mem_next),
        .wb_next  (wb_next)
    );

    // Load-use detection against the load sitting in EX; flush overrides it.
    // rs2 is always compared, so an instruction without rs2 may stall needlessly.
    always_comb begin
        load_use = id_valid && ex_entry.valid && ex_entry.mem_read &&
                   (ex_entry.rd != '0) &&
                   ((ex_entry.rd == id_rs1) || (ex_entry.rd == id_rs2));
        stall    = load_use && !flush;
        load_en  = id_valid && !stall && !flush;
    end

    // Selects for the instruction entering EX, against the producers entering MEM and WB
    always_comb begin
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
        if (load_en) begin
            fwd_a_d = fwd_select(mem_next, wb_next, id_rs1);
            fwd_b_d = fwd_select(mem_next, wb_next, id_rs2);
        end
    end

    // Select registers, held for the whole EX cycle of their instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

`ifdef FWD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count stall cycles; wraps naturally at 2^STALL_CNT_W
    always_comb begin
        stall_cnt_d = stall_cnt_q + STALL_CNT_W'(stall);
    end

    // Stall counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    assign stall_count = stall_cnt_q;
`else
    // Counter disabled: no stall_count port and no counter state.
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed testbench for fwd_hazard_unit. Inputs change on the falling edge;
// outputs are sampled 1 time unit later, so stall reflects the ID inputs just
// applied and the selects belong to the instruction that entered EX at the
// preceding rising edge. Builds with or without FWD_STALL_CNT_EN.
module tb_fwd_hazard_unit;
    import fwd_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              id_valid = 1'b0;
    logic [REG_AW-1:0] id_rs1 = '0;
    logic [REG_AW-1:0] id_rs2 = '0;
    logic [REG_AW-1:0] id_rd = '0;
    logic              id_reg_write = 1'b0;
    logic              id_mem_read = 1'b0;
    logic              flush = 1'b0;
    logic              stall;
    logic [SEL_W-1:0]  fwd_a_sel;
    logic [SEL_W-1:0]  fwd_b_sel;
`ifdef FWD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .stall        (stall),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock cycle: apply reset/ID/flush at the falling edge, then settle
    task automatic cyc(input logic r, input logic v, input logic fl,
                       input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                       input logic [REG_AW-1:0] rs2, input logic rw, input logic mr);
        @(negedge clk);
        rst          = r;
        id_valid     = v;
        flush        = fl;
        id_rd        = rd;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_reg_write = rw;
        id_mem_read  = mr;
        #1;
    endtask

    task automatic nop();
        cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        repeat (3) nop();
    endtask

    task automatic alu(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1,
                       input logic [REG_AW-1:0] rs2);
        cyc(1'b0, 1'b1, 1'b0, rd, rs1, rs2, 1'b1, 1'b0);
    endtask

    task automatic lw(input logic [REG_AW-1:0] rd, input logic [REG_AW-1:0] rs1);
        cyc(1'b0, 1'b1, 1'b0, rd, rs1, 5'd0, 1'b1, 1'b1);
    endtask

    task automatic check_sels(input string tag, input logic [SEL_W-1:0] ea,
                              input logic [SEL_W-1:0] eb);
        check({tag, "_a"}, 32'(fwd_a_sel), 32'(ea));
        check({tag, "_b"}, 32'(fwd_b_sel), 32'(eb));
    endtask

    task automatic check_cnt(input string tag);
`ifdef FWD_STALL_CNT_EN
        check(tag, stall_count, 32'(exp_cnt));
`else
        if (tag.len() == 0) $display("empty counter tag");
`endif
    endtask

    initial begin
        // Reset state
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        nop();
        check("rst_stall", 32'(stall), 0);
        check_sels("rst", FWD_REG, FWD_REG);
        check_cnt("rst_cnt");

        // 1: add x5,x1,x2 ; add x6,x5,x3 -> A from EX/MEM
        alu(5'd5, 5'd1, 5'd2);
        check("t1_p_stall", 32'(stall), 0);
        alu(5'd6, 5'd5, 5'd3);
        check("t1_c_stall", 32'(stall), 0);
        nop();
        check_sels("t1", FWD_EXMEM, FWD_REG);
        drain();

        // 2: add x5 ; nop ; sub x7,x4,x5 -> B from MEM/WB
        alu(5'd5, 5'd1, 5'd2);
        nop();
        alu(5'd7, 5'd4, 5'd5);
        nop();
        check_sels("t2", FWD_REG, FWD_MEMWB);
        drain();

        // 3: add x7 ; add x7 ; or x8,x7,x7 -> EX/MEM priority on both
        alu(5'd7, 5'd1, 5'd2);
        alu(5'd7, 5'd3, 5'd4);
        alu(5'd8, 5'd7, 5'd7);
        nop();
        check_sels("t3", FWD_EXMEM, FWD_EXMEM);
        drain();

        // 4: lw x8 ; add x9,x8,x8 -> one stall cycle, bubble, then MEM/WB
        lw(5'd8, 5'd1);
        alu(5'd9, 5'd8, 5'd8);
        check("t4_stall", 32'(stall), 1);
        check_cnt("t4_cnt0");
        exp_cnt++;
        alu(5'd9, 5'd8, 5'd8);
        check("t4_stall_once", 32'(stall), 0);
        check_sels("t4_bubble", FWD_REG, FWD_REG);
        check_cnt("t4_cnt1");
        nop();
        check_sels("t4_use", FWD_MEMWB, FWD_MEMWB);
        drain();

        // 4b: load hit on rs2 only
        lw(5'd10, 5'd1);
        alu(5'd11, 5'd1, 5'd10);
        check("t4b_stall", 32'(stall), 1);
        exp_cnt++;
        alu(5'd11, 5'd1, 5'd10);
        check("t4b_stall_once", 32'(stall), 0);
        nop();
        check_sels("t4b_use", FWD_REG, FWD_MEMWB);
        check_cnt("t4b_cnt");
        drain();

        // 5: x0 never forwards and never stalls
        alu(5'd0, 5'd1, 5'd2);
        alu(5'd3, 5'd0, 5'd0);
        nop();
        check_sels("t5_x0", FWD_REG, FWD_REG);
        drain();
        lw(5'd0, 5'd1);
        alu(5'd9, 5'd0, 5'd0);
        check("t5_lw_x0_stall", 32'(stall), 0);
        nop();
        check_sels("t5_lw_x0", FWD_REG, FWD_REG);
        drain();

        // 6: flush in the load-use stall cycle
        lw(5'd8, 5'd1);
        cyc(1'b0, 1'b1, 1'b1, 5'd9, 5'd8, 5'd8, 1'b1, 1'b0);
        check("t6_flush_stall", 32'(stall), 0);
        nop();
        check("t6_after_stall", 32'(stall), 0);
        check_sels("t6_bubble", FWD_REG, FWD_REG);
        check_cnt("t6_cnt");
        drain();

        // Reset in the middle of a load-use stall
        lw(5'd8, 5'd1);
        cyc(1'b1, 1'b1, 1'b0, 5'd9, 5'd8, 5'd8, 1'b1, 1'b0);
        exp_cnt = 0;
        alu(5'd9, 5'd8, 5'd8);
        check("rst_mid_stall", 32'(stall), 0);
        check_cnt("rst_mid_cnt");
        nop();
        check_sels("rst_mid", FWD_REG, FWD_REG);
        drain();

        // Reset while a forwarding consumer enters EX, then normal operation resumes
        alu(5'd5, 5'd1, 5'd2);
        cyc(1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 5'd5, 1'b1, 1'b0);
        nop();
        check("rst_fwd_stall", 32'(stall), 0);
        check_sels("rst_fwd", FWD_REG, FWD_REG);
        alu(5'd5, 5'd1, 5'd2);
        alu(5'd6, 5'd5, 5'd5);
        nop();
        check_sels("post_rst", FWD_EXMEM, FWD_EXMEM);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
